// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display driver: active-low segment
// patterns, converter state encodings and the BCD nibble type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t COMMIT = 2'd2;

    typedef logic [3:0] bcd_t;

    function automatic logic [6:0] seg_decode(input bcd_t nib);
        case (nib)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep, last-wins
// pending slot for values loaded while a conversion is running.
module bcd_converter #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 14,
    parameter int MAX_VALUE   = 9999
) (
    input  logic                      MasterClock,
    input  logic                      Reset,
    input  logic [VALUE_WIDTH-1:0]    Value,
    input  logic                      ValueLoad,
    output logic                      Busy,
    output logic [4*NUM_DIGITS-1:0]   Bcd,
    output logic                      Done
);
    import seg_pkg::*;

    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam logic [VALUE_WIDTH-1:0] MAX_V = VALUE_WIDTH'(MAX_VALUE);

    state_t                 state;
    logic                   busy_q;
    logic                   pending;
    logic [VALUE_WIDTH-1:0] pend_val;
    logic [VALUE_WIDTH-1:0] load_src;
    logic [VALUE_WIDTH-1:0] load_sat;
    logic [VALUE_WIDTH-1:0] bin;
    logic [BW-1:0]          acc;
    logic [BW-1:0]          acc_adj;
    logic [CNT_W-1:0]       cnt;

    // A fresh strobe in IDLE takes precedence over an older pending value.
    always_comb begin
        load_src = ValueLoad ? Value : pend_val;
        load_sat = (load_src > MAX_V) ? MAX_V : load_src;
    end

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            pending  <= 1'b0;
            pend_val <= '0;
            bin      <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ValueLoad || pending) begin
                        bin     <= load_sat;
                        acc     <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        pending <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[BW-2:0], bin, 1'b0};
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_WIDTH - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Leaving COMMIT always passes through IDLE, giving the one-cycle Busy gap.
            if (ValueLoad && state != IDLE) begin
                pend_val <= Value;
                pending  <= 1'b1;
            end
        end
    end

    assign Busy = busy_q;
    assign Bcd  = acc;
    assign Done = (state == COMMIT);

endmodule

// File: rtl/seg_display_driver.sv
// Score display: BCD conversion plus one-digit-per-tick scan of a common-anode
// display. Define LEADING_ZERO_BLANK_EN to blank digits above the top non-zero one.
module seg_display_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 14,
    parameter int MAX_VALUE   = 9999
) (
    input  logic                   MasterClock,
    input  logic                   Reset,
    input  logic                   ScanTick,
    input  logic [VALUE_WIDTH-1:0] Value,
    input  logic                   ValueLoad,
    output logic                   Busy,
    output logic [NUM_DIGITS-1:0]  Anode,
    output logic [6:0]             Seg,
    output logic                   Dp
);
    import seg_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);
`else
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic                    conv_done;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blank_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [6:0]              seg_next;
    bcd_t                    nib;

    bcd_converter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .VALUE_WIDTH (VALUE_WIDTH),
        .MAX_VALUE   (MAX_VALUE)
    ) u_conv (
        .MasterClock (MasterClock),
        .Reset       (Reset),
        .Value       (Value),
        .ValueLoad   (ValueLoad),
        .Busy        (Busy),
        .Bcd         (conv_bcd),
        .Done        (conv_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;
    always_comb begin
        blank_next = '0;
        seen_nz    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            if (conv_bcd[4*(NUM_DIGITS-1-k) +: 4] != 4'd0)
                seen_nz = 1'b1;
            blank_next[NUM_DIGITS-1-k] = !seen_nz;
        end
    end
`else
    always_comb blank_next = '0;
`endif

    always_comb begin
        idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        nib      = disp[4*idx_next +: 4];
        anode_next           = '1;
        anode_next[idx_next] = 1'b0;
        seg_next = blank[idx_next] ? SEG_BLANK : seg_decode(nib);
    end

    // Scan reads disp before this edge's commit lands, so digits are never torn.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            disp  <= '0;
            blank <= BLANK_RST;
            idx   <= IDX_W'(NUM_DIGITS - 1);
            Anode <= '1;
            Seg   <= SEG_BLANK;
        end else begin
            if (conv_done) begin
                disp  <= conv_bcd;
                blank <= blank_next;
            end
            if (ScanTick) begin
                idx   <= idx_next;
                Anode <= anode_next;
                Seg   <= seg_next;
            end
        end
    end

    assign Dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver (default 4 digits, 14-bit value).
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        vl;
    logic [13:0] val;
    logic        busy;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_driver #(
        .NUM_DIGITS  (4),
        .VALUE_WIDTH (14),
        .MAX_VALUE   (9999)
    ) dut (
        .MasterClock (clk),
        .Reset       (rst),
        .ScanTick    (tick),
        .Value       (val),
        .ValueLoad   (vl),
        .Busy        (busy),
        .Anode       (anode),
        .Seg         (seg),
        .Dp          (dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input int v);
        int dig;
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 7'h7F;
`endif
        dig = (v / p) % 10;
        case (dig)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        val = 14'(v);
        vl  = 1'b1;
        step();
        vl  = 1'b0;
    endtask

    task automatic expect_digit(input string tag, input int d, input int v);
        logic [3:0] ea;
        ea = ~(4'b0001 << d);
        check({tag, "_anode"}, {28'd0, anode}, {28'd0, ea});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(d, v)});
        check({tag, "_dp"}, {31'd0, dp}, 32'd1);
    endtask

    // Assumes the scan index sits on the top digit, so four ticks cover digits 0..3.
    task automatic scan_check(input string tag, input int v);
        tick = 1'b1;
        for (int d = 0; d < 4; d++) begin
            step();
            expect_digit(tag, d, v);
        end
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; vl = 1'b0; val = '0;
        step();
        step();
        check("rst_anode", {28'd0, anode}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();
        scan_check("zero", 0);

        // 1234: Busy for 15 cycles, scan tick coinciding with COMMIT sees old value
        load(1234);
        check("b1234_busy0", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 14; i++) begin
            step();
            check("b1234_busy", {31'd0, busy}, 32'd1);
        end
        tick = 1'b1;
        step();
        check("b1234_done", {31'd0, busy}, 32'd0);
        expect_digit("commit_old", 0, 0);
        for (int d = 1; d < 4; d++) begin
            step();
            expect_digit("commit_new", d, 1234);
        end
        tick = 1'b0;
        scan_check("v1234", 1234);

        load(16383);
        repeat (16) step();
        scan_check("sat", 9999);

        // Pending: 42, then 77 and 88 while busy; 88 replaces 77
        load(42);
        step();
        step();
        val = 14'd77; vl = 1'b1;
        step();
        val = 14'd88;
        step();
        vl = 1'b0;
        repeat (10) step();
        check("pend_busy_e14", {31'd0, busy}, 32'd1);
        step();
        check("pend_gap", {31'd0, busy}, 32'd0);
        step();
        check("pend_restart", {31'd0, busy}, 32'd1);
        scan_check("v42", 42);
        repeat (11) step();
        check("pend_done", {31'd0, busy}, 32'd0);
        step();
        check("pend_idle", {31'd0, busy}, 32'd0);
        scan_check("v88", 88);

        // Reset mid-SHIFT, with a coincident load that must be ignored
        load(1234);
        repeat (5) step();
        rst = 1'b1; vl = 1'b1; val = 14'd5;
        step();
        rst = 1'b0; vl = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_anode", {28'd0, anode}, 32'hF);
        check("mrst_seg", {25'd0, seg}, 32'h7F);
        step();
        check("mrst_noload", {31'd0, busy}, 32'd0);
        scan_check("mrst_zero", 0);
        load(5);
        repeat (16) step();
        scan_check("v5", 5);

        load(7);
        repeat (16) step();
        scan_check("v7", 7);
        load(0);
        repeat (16) step();
        scan_check("v0", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
